// File: rtl/flush_bank_sequencer.sv
// Multi-bank flush/clean sequencer: walks the banks selected by a mask, issuing
// back-pressured flush writes and optional clean writes, then a done/transfer handshake.
module flush_bank_sequencer #(
  parameter int TPO      = 8,
  parameter int NumBanks = 2,
  parameter bit CleanEn  = 1'b1,
  localparam int AddrWidth = (TPO > 1) ? $clog2(TPO) : 1,
  localparam int BankWidth = (NumBanks > 1) ? $clog2(NumBanks) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_req_i,
  input  logic [NumBanks-1:0]  bank_mask_i,
  input  logic                 flush_ready_i,
  input  logic                 transfer_output_ack_i,
  output logic [BankWidth-1:0] bank_sel_o,
  output logic [AddrWidth-1:0] reg_addr_o,
  output logic                 flush_we_o,
  output logic                 clean_we_o,
  output logic                 flush_ack_o,
  output logic                 transfer_output_req_o,
  output logic                 busy_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_CLEAN, S_NEXT, S_DONE, S_WAIT
  } state_e;

  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(TPO - 1);

  state_e               state_q, state_d;
  logic [NumBanks-1:0]  mask_q, mask_d;
  logic [BankWidth-1:0] bank_q, bank_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [NumBanks-1:0]  remain;

  // Priority pick of the lowest pending bank.
  function automatic logic [BankWidth-1:0] lowest(input logic [NumBanks-1:0] m);
    logic [BankWidth-1:0] r;
    r = '0;
    for (int i = NumBanks - 1; i >= 0; i--) begin
      if (m[i]) r = BankWidth'(i);
    end
    return r;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      bank_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      bank_q  <= bank_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    bank_d  = bank_q;
    addr_d  = addr_q;
    remain  = mask_q & ~(NumBanks'(1) << bank_q);
    unique case (state_q)
      S_IDLE: begin
        if (flush_req_i) begin
          mask_d = bank_mask_i;
          addr_d = '0;
          if (|bank_mask_i) begin
            bank_d  = lowest(bank_mask_i);
            state_d = S_FLUSH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FLUSH: begin
        if (flush_ready_i) begin
          if (addr_q == LastAddr) begin
            addr_d  = '0;
            state_d = CleanEn ? S_CLEAN : S_NEXT;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      S_CLEAN: begin
        if (addr_q == LastAddr) begin
          addr_d  = '0;
          state_d = S_NEXT;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_NEXT: begin
        mask_d = remain;
        addr_d = '0;
        if (|remain) begin
          bank_d  = lowest(remain);
          state_d = S_FLUSH;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_WAIT;
      S_WAIT: if (transfer_output_ack_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bank_sel_o            = bank_q;
    reg_addr_o            = addr_q;
    flush_we_o            = (state_q == S_FLUSH);
    clean_we_o            = (state_q == S_CLEAN);
    flush_ack_o           = (state_q == S_DONE);
    transfer_output_req_o = (state_q == S_WAIT);
    busy_o                = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_flush_bank_sequencer.sv
// Bench for flush_bank_sequencer: two configurations (TPO=8/2 banks/clean, TPO=5/3 banks/no clean)
// checked cycle by cycle against an ordered list of expected writes and a cycle-count formula.
module tb_flush_bank_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       req [2];
  logic [2:0] m   [2];
  logic       rdy [2];
  logic       ack [2];

  logic [0:0] a_bank; logic [2:0] a_addr;
  logic [1:0] b_bank; logic [2:0] b_addr;
  logic a_fwe, a_cwe, a_fack, a_xreq, a_busy;
  logic b_fwe, b_cwe, b_fack, b_xreq, b_busy;

  flush_bank_sequencer #(.TPO(8), .NumBanks(2), .CleanEn(1'b1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .flush_req_i(req[0]), .bank_mask_i(m[0][1:0]),
    .flush_ready_i(rdy[0]), .transfer_output_ack_i(ack[0]),
    .bank_sel_o(a_bank), .reg_addr_o(a_addr), .flush_we_o(a_fwe), .clean_we_o(a_cwe),
    .flush_ack_o(a_fack), .transfer_output_req_o(a_xreq), .busy_o(a_busy));

  flush_bank_sequencer #(.TPO(5), .NumBanks(3), .CleanEn(1'b0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_req_i(req[1]), .bank_mask_i(m[1]),
    .flush_ready_i(rdy[1]), .transfer_output_ack_i(ack[1]),
    .bank_sel_o(b_bank), .reg_addr_o(b_addr), .flush_we_o(b_fwe), .clean_we_o(b_cwe),
    .flush_ack_o(b_fack), .transfer_output_req_o(b_xreq), .busy_o(b_busy));

  int dsel = 0;
  int o_bank, o_addr;
  logic o_fwe, o_cwe, o_fack, o_xreq, o_busy;
  always_comb begin
    o_bank = (dsel != 0) ? int'(b_bank) : int'(a_bank);
    o_addr = (dsel != 0) ? int'(b_addr) : int'(a_addr);
    o_fwe  = (dsel != 0) ? b_fwe  : a_fwe;
    o_cwe  = (dsel != 0) ? b_cwe  : a_cwe;
    o_fack = (dsel != 0) ? b_fack : a_fack;
    o_xreq = (dsel != 0) ? b_xreq : a_xreq;
    o_busy = (dsel != 0) ? b_busy : a_busy;
  end

  int checks = 0;
  int errors = 0;
  int expq[$];

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (dut %0d, t=%0t)", nm, got, exp, dsel, $time);
    end
  endtask

  function automatic int enc(input int kind, input int bank, input int addr);
    return kind * 10000 + bank * 100 + addr;
  endfunction

  // Expected write order derived from the bank/register walk rules.
  task automatic build(input int d, input int mask, output int base, output int nwr);
    int tpo, nb, cl, cnt;
    tpo = (d != 0) ? 5 : 8;
    nb  = (d != 0) ? 3 : 2;
    cl  = (d != 0) ? 0 : 1;
    cnt = 0;
    expq.delete();
    for (int b = 0; b < nb; b++) begin
      if (mask[b]) begin
        cnt++;
        for (int a = 0; a < tpo; a++) expq.push_back(enc(0, b, a));
        if (cl != 0) for (int a = 0; a < tpo; a++) expq.push_back(enc(1, b, a));
      end
    end
    nwr  = expq.size();
    base = 1 + cnt * (tpo * (cl + 1) + 1);
  endtask

  typedef struct {
    int d; int mask; int stall_mode; int ack_wait; bit noise;
    int exp_base; int exp_stalls; int exp_writes;
  } vec_t;

  // Called at a negedge with the selected DUT idle; request is sampled at the next edge (edge 0).
  task automatic run(input vec_t v);
    int cyc, stalls, nwr, ack_at, exp_ack, base, mwr;
    bit stalled3, stalled5;
    build(v.d, v.mask, base, mwr);
    chk("model_base", base, v.exp_base);
    chk("model_writes", mwr, v.exp_writes);
    dsel = v.d;
    req[v.d] = 1'b1;
    m[v.d]   = 3'(v.mask);
    rdy[v.d] = 1'b1;
    ack[v.d] = 1'b0;
    cyc = 1; stalls = 0; nwr = 0; ack_at = -1;
    stalled3 = 1'b0; stalled5 = 1'b0;
    forever begin
      @(negedge clk);
      exp_ack = v.exp_base + stalls;
      chk("flush_ack", int'(o_fack), int'(cyc == exp_ack));
      chk("busy", int'(o_busy), int'(ack_at < 0 || cyc <= ack_at));
      chk("xfer_req", int'(o_xreq), int'(cyc > exp_ack && (ack_at < 0 || cyc <= ack_at)));
      chk("strobe_excl", int'(o_fwe && o_cwe), 0);
      if (o_fwe || o_cwe) begin
        if (expq.size() == 0) chk("extra_write", 1, 0);
        else chk(o_fwe ? "flush_beat" : "clean_beat", enc(int'(o_cwe), o_bank, o_addr), expq[0]);
      end
      if (o_cwe && expq.size() != 0) begin
        void'(expq.pop_front());
        nwr++;
      end
      if (ack_at >= 0 && cyc > ack_at) break;
      req[v.d] = 1'b0;
      ack[v.d] = 1'b0;
      case (v.stall_mode)
        1: rdy[v.d] = ($urandom_range(0, 3) != 0);
        2: begin
          rdy[v.d] = 1'b1;
          if (o_fwe && o_bank == 0 && o_addr == 3 && !stalled3) begin rdy[v.d] = 1'b0; stalled3 = 1'b1; end
          if (o_fwe && o_bank == 0 && o_addr == 5 && !stalled5) begin rdy[v.d] = 1'b0; stalled5 = 1'b1; end
        end
        default: rdy[v.d] = 1'b1;
      endcase
      if (o_fwe) begin
        if (rdy[v.d]) begin
          if (expq.size() != 0) void'(expq.pop_front());
          nwr++;
        end else stalls++;
      end
      if (v.noise && o_fwe && $urandom_range(0, 2) == 0) begin
        req[v.d] = 1'b1;
        m[v.d]   = 3'($urandom_range(0, 7));
        ack[v.d] = 1'b1;
      end
      if (cyc == exp_ack + 1 + v.ack_wait) begin
        ack[v.d] = 1'b1;
        ack_at = cyc;
      end
      cyc++;
      if (cyc > 3000) begin
        chk("timeout", 1, 0);
        break;
      end
    end
    req[v.d] = 1'b0;
    ack[v.d] = 1'b0;
    rdy[v.d] = 1'b0;
    chk("queue_drained", expq.size(), 0);
    chk("writes", nwr, v.exp_writes);
    if (v.exp_stalls >= 0) chk("stalls", stalls, v.exp_stalls);
  endtask

  vec_t tbl[6];
  vec_t rv;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin req[i] = 1'b0; m[i] = '0; rdy[i] = 1'b0; ack[i] = 1'b0; end
    //          d  mask mode aw noise base stalls writes
    tbl[0] = '{0, 1, 0, 2, 1'b0, 18, 0, 16};
    tbl[1] = '{0, 3, 2, 1, 1'b0, 35, 2, 32};
    tbl[2] = '{0, 0, 0, 0, 1'b0, 1,  0, 0};
    tbl[3] = '{1, 5, 0, 1, 1'b0, 13, 0, 10};
    tbl[4] = '{0, 2, 0, 0, 1'b1, 18, 0, 16};
    tbl[5] = '{1, 7, 0, 0, 1'b1, 19, 0, 15};

    #12;
    for (int d = 0; d < 2; d++) begin
      dsel = d; #1;
      chk("rst_busy", int'(o_busy), 0);
      chk("rst_fwe", int'(o_fwe), 0);
      chk("rst_cwe", int'(o_cwe), 0);
      chk("rst_fack", int'(o_fack), 0);
      chk("rst_xreq", int'(o_xreq), 0);
      chk("rst_bank", o_bank, 0);
      chk("rst_addr", o_addr, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run(tbl[i]);

    // Reset in the middle of bank 1's clean pass.
    dsel = 0;
    req[0] = 1'b1; m[0] = 3'd3; rdy[0] = 1'b1;
    @(negedge clk);
    req[0] = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (o_cwe && o_bank == 1 && o_addr == 2) break;
      @(negedge clk);
    end
    chk("reached_clean_b1", int'(o_cwe && o_bank == 1), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(o_busy), 0);
    chk("mid_rst_cwe", int'(o_cwe), 0);
    chk("mid_rst_fwe", int'(o_fwe), 0);
    chk("mid_rst_bank", o_bank, 0);
    chk("mid_rst_addr", o_addr, 0);
    chk("mid_rst_xreq", int'(o_xreq), 0);
    @(negedge clk);
    rst_n = 1'b1;
    rdy[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_idle", int'(o_busy), 0);
    run(tbl[1]);

    for (int r = 0; r < 14; r++) begin
      int nb, mask, base, nw;
      rv.d = $urandom_range(0, 1);
      nb = (rv.d != 0) ? 3 : 2;
      mask = $urandom_range(0, (1 << nb) - 1);
      build(rv.d, mask, base, nw);
      rv.mask = mask; rv.stall_mode = 1; rv.ack_wait = $urandom_range(0, 3);
      rv.noise = 1'($urandom_range(0, 1)); rv.exp_base = base; rv.exp_stalls = -1; rv.exp_writes = nw;
      if (rv.d != dsel) @(negedge clk);
      run(rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flush_bank_sequencer.md
# flush_bank_sequencer

Multi-bank output flush/clean sequencer for the Xnorator output path: on request, it walks the accumulator register banks selected by a mask. For each bank it issues TPO flush writes under downstream back-pressure, then optionally TPO clean writes. It finishes with a flush-done pulse and a transfer request/acknowledge handshake. It is the parametrised successor of the single-bank flush FSM: generalised bank count, back-pressured flush, optional clean phase and a busy indication.

## Interface
- TPO, default 8: registers per bank; legal range ≥1.
- NumBanks, default 2: number of banks; legal range ≥1.
- CleanEn, default 1: 1 = run a clean pass after each bank's flush; 0 = skip the clean pass.
- AddrWidth (localparam): max(1, $clog2(TPO)).
- BankWidth (localparam): max(1, $clog2(NumBanks)).

- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- flush_req_i  in  1  start request; sampled only in Idle
- bank_mask_i  in  NumBanks  banks to process; latched with flush_req_i
- flush_ready_i  in  1  downstream accepts the flush write this cycle
- transfer_output_ack_i  in  1  acknowledge for transfer_output_req_o
- bank_sel_o  out  BankWidth  bank currently addressed
- reg_addr_o  out  AddrWidth  register index within the bank
- flush_we_o  out  1  flush write valid
- clean_we_o  out  1  clean (zero) write
- flush_ack_o  out  1  one-cycle pulse when all banks are done
- transfer_output_req_o  out  1  held high until acknowledged
- busy_o  out  1  high whenever state ≠ Idle

## Operation
- **States:** Idle, Flush, Clean, NextBank, Done, Wait.
- **Outputs:** Moore outputs decoded from the registered state, bank index and address counter. There is no combinational path from any input to any output.
- **Idle**
  - On flush_req_i = 1: latch bank_mask_i into mask_q.
  - If mask_q ≠ 0: select the lowest set bit as the bank, clear the address to 0, go to Flush.
  - If mask_q = 0: go directly to Done.
- **Flush**
  - flush_we_o = 1.
  - A beat is accepted when flush_we_o and flush_ready_i are both 1 at a rising edge.
  - On an accepted beat with address < TPO-1: increment the address.
  - On an accepted beat with address = TPO-1: clear the address to 0, then go to Clean if CleanEn = 1, else go to NextBank.
  - When flush_ready_i = 0: the address and bank are held stable.
- **Clean**
  - clean_we_o = 1 every cycle; there is no back-pressure.
  - The address increments each cycle; after address TPO-1, go to NextBank.
- **NextBank** (1 cycle, no write strobes)
  - Clear the current bank's bit in mask_q.
  - If any bit remains: select the lowest remaining set bit, clear the address to 0, go to Flush.
  - Otherwise: go to Done.
- **Done:** flush_ack_o = 1 for exactly one cycle, then go to Wait.
- **Wait:** transfer_output_req_o = 1; on transfer_output_ack_i = 1, go to Idle.
- **Ignored inputs**
  - flush_req_i outside Idle.
  - transfer_output_ack_i outside Wait.
  - Mask bits at or above NumBanks do not exist (the port is NumBanks wide).
- **Counter widths:** the address counter is AddrWidth bits. It never exceeds TPO-1, so there is no wrap for non-power-of-2 TPO. The bank index never exceeds NumBanks-1.
- **Reset (including mid-operation):**
  - State → Idle, mask_q → 0, address and bank → 0.
  - All outputs go to 0 asynchronously: bank_sel_o, reg_addr_o, flush_we_o, clean_we_o, flush_ack_o, transfer_output_req_o, busy_o.
  - No partial pass resumes after reset.

## Timing
- **Latency from request:** flush_req_i sampled at edge 0 → flush_we_o = 1 with reg_addr_o = 0 in cycle 1; busy_o = 1 from cycle 1.
- **Single bank, flush_ready_i held at 1, CleanEn = 1:**
  - flush_we_o in cycles 1..TPO.
  - clean_we_o in cycles TPO+1..2TPO.
  - NextBank in cycle 2TPO+1.
  - flush_ack_o in cycle 2TPO+2.
  - transfer_output_req_o from cycle 2TPO+3.
- **Extra cycles:**
  - Each additional bank adds 2TPO+1 cycles.
  - Each cycle with flush_ready_i = 0 during Flush adds one cycle.
  - CleanEn = 0 removes the TPO clean cycles per bank.
- **Transfer handshake:** ack sampled at edge N → transfer_output_req_o = 0 and busy_o = 0 in cycle N+1. Ack may already be high on the first Wait cycle.
- **Back-to-back requests:** a new flush_req_i is accepted on the first Idle cycle after Wait.

## Test plan
- TPO=8, NumBanks=2, mask=2'b01, ready held at 1 → bank 0: flush addr 0..7 in cycles 1–8, clean 0..7 in cycles 9–16; flush_ack_o in cycle 18; req high from cycle 19; ack in cycle 21 → Idle in cycle 22.
- mask=2'b11, with flush_ready_i = 0 on the beats at addr 3 and addr 5 of bank 0 → addr held during stalls; exactly 8 accepted flush beats per bank; bank_sel_o goes 0 then 1; flush_ack_o 2 cycles later than the unstalled run.
- mask=0 → no write strobes; flush_ack_o in cycle 1; req in cycle 2; busy_o high through Wait.
- CleanEn=0, TPO=5, NumBanks=3, mask=3'b101 → flush banks 0 then 2 with addr 0..4; clean_we_o never asserted; bank 1 skipped.
- Assert rst_ni low mid-Clean of bank 1 → all outputs 0 immediately; after release, Idle; a new request restarts at bank 0, addr 0.
- flush_req_i pulsed during Flush, and ack pulsed during Flush → both ignored; the sequence completes unchanged.
